// File: rtl/mux8_rr_arbiter_if.sv
// mux8_rr_arbiter_if: bundles the request, grant and handshake signals shared by the requesters, the arbiter and the mux/consumer pair
interface mux8_rr_arbiter_if;
    logic [7:0] req;
    logic [7:0] lock;
    logic       out_ready;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       out_valid;
    modport master (input req, lock, out_ready, output gnt, sel, out_valid);
    modport slave  (output req, lock, out_ready, input gnt, sel, out_valid);
endinterface

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin arbiter driving the 8:1 mux select and holding it until the consumer accepts the transfer.
// Define MUX8_RR_ARB_LOCK_EN to let a locked requester keep up to HOLD_MAX back-to-back transfers.
module mux8_rr_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input logic               clk,
    input logic               rst_n,
    mux8_rr_arbiter_if.master bus
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t     state, state_n;
    logic [7:0] gnt_n;
    logic [2:0] sel_n, ptr, ptr_n, scan, win;
    logic       valid_n, xfer, found, keep;
`ifdef MUX8_RR_ARB_LOCK_EN
    logic [3:0] hold_cnt, hold_n;
`endif
    always_comb begin
        xfer = state == GRANT && bus.out_ready;
        // On a transfer the scan starts just past the served requester, so it is scanned last
        scan = xfer ? bus.sel + 3'd1 : ptr;
        found = 1'b0;
        win = scan;
        for (int k = 7; k >= 0; k--) begin
            if (bus.req[scan + 3'(k)]) begin
                found = 1'b1;
                win = scan + 3'(k);
            end
        end
`ifdef MUX8_RR_ARB_LOCK_EN
        keep = xfer && bus.lock[bus.sel] && bus.req[bus.sel] && int'(hold_cnt) < HOLD_MAX - 1;
        hold_n = keep ? hold_cnt + 4'd1 : (xfer || !bus.req[bus.sel]) ? 4'd0 : hold_cnt;
`else
        keep = 1'b0;
`endif
        state_n = state;
        gnt_n = bus.gnt;
        sel_n = bus.sel;
        valid_n = bus.out_valid;
        ptr_n = (xfer && !keep) ? bus.sel + 3'd1 : ptr;
        if ((state == IDLE || xfer) && !keep) begin
            state_n = found ? GRANT : IDLE;
            sel_n = found ? win : bus.sel;
            gnt_n = found ? 8'd1 << win : 8'd0;
            valid_n = found;
        end else if (state == GRANT && !bus.out_ready && !bus.req[bus.sel]) begin
            state_n = IDLE;
            gnt_n = 8'd0;
            valid_n = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            bus.gnt <= 8'd0;
            bus.sel <= 3'd0;
            bus.out_valid <= 1'b0;
            ptr <= 3'd0;
`ifdef MUX8_RR_ARB_LOCK_EN
            hold_cnt <= 4'd0;
`endif
        end else begin
            state <= state_n;
            bus.gnt <= gnt_n;
            bus.sel <= sel_n;
            bus.out_valid <= valid_n;
            ptr <= ptr_n;
`ifdef MUX8_RR_ARB_LOCK_EN
            hold_cnt <= hold_n;
`endif
        end
    end
endmodule
